// File: rtl/ixc_assign_arb_32.sv
// Round-robin arbiter that shares one registered W-bit assign path (L <= R) among NREQ
// requesters, letting each grantee stream up to MAX_BURST words with out_valid/out_ready flow.
module ixc_assign_arb_32 #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned W         = 32,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned GW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      L,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NREQ-1:0]   grant,
  output logic [GW-1:0]     grant_id
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [NREQ-1:0] grant_q;
  logic [GW-1:0]   grant_id_q;
  logic [GW-1:0]   rr_ptr_q;
  logic [7:0]      burst_cnt_q;
  logic [W-1:0]    l_q;
  logic            out_valid_q;

  logic [W-1:0]    words [NREQ];
  logic            pick_found;
  logic [GW-1:0]   pick_id;
  logic [GW:0]     sum;
  logic [GW-1:0]   cand;
  logic            cur_valid;
  logic [W-1:0]    cur_data;
  logic            ready_bit;
  logic            accept;
  logic            last_word;
  logic [GW-1:0]   next_ptr;

  for (genvar i = 0; i < NREQ; i++) begin : g_words
    assign words[i] = req_data[i*W +: W];
  end

  // First valid requester scanning upward from rr_ptr, wrapping modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    sum        = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr_q} + (GW+1)'(i);
      if (sum >= (GW+1)'(NREQ)) begin
        sum = sum - (GW+1)'(NREQ);
      end
      cand = sum[GW-1:0];
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  assign cur_valid = req_valid[grant_id_q];
  assign cur_data  = words[grant_id_q];
  assign ready_bit = ~out_valid_q | out_ready;
  assign accept    = (state_q == StBusy) & cur_valid & ready_bit;
  assign last_word = (burst_cnt_q == 8'(MAX_BURST - 1));
  assign next_ptr  = (grant_id_q == GW'(NREQ - 1)) ? '0 : grant_id_q + GW'(1);

  assign req_ready = ((state_q == StBusy) && ready_bit) ? grant_q : '0;
  assign L         = l_q;
  assign out_valid = out_valid_q;
  assign grant     = grant_q;
  assign grant_id  = grant_id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      l_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // A fresh word may overwrite the held one in the same edge downstream takes it.
      if (accept) begin
        l_q         <= cur_data;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (pick_found) begin
            state_q     <= StBusy;
            grant_q     <= NREQ'(1) << pick_id;
            grant_id_q  <= pick_id;
            burst_cnt_q <= '0;
          end
        end
        StBusy: begin
          if (accept) begin
            burst_cnt_q <= burst_cnt_q + 8'd1;
          end
          if (!cur_valid || (accept && last_word)) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= next_ptr;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ixc_assign_arb_32.sv
// Directed bench for ixc_assign_arb_32: requester models stream base+index words, and a
// scoreboard of predicted words is popped whenever the output handshake completes.
module tb_ixc_assign_arb_32;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [31:0]  L;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   grant;
  logic [1:0]   grant_id;

  logic [7:0]   remaining [4];
  logic [7:0]   idx [4];
  logic [31:0]  base [4];
  logic [3:0]   hs;
  logic         mon_fire;
  logic [31:0]  mon_l;
  logic [31:0]  exp_q [$];
  logic [3:0]   gs [$];
  logic [3:0]   exp_g [5];
  logic [3:0]   prev;
  int           passed = 0;
  int           total = 0;

  ixc_assign_arb_32 #(.NREQ(4), .W(32), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .L         (L),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < 4; i++) begin
      req_valid[i]        = (remaining[i] != 8'd0);
      req_data[i*32 +: 32] = base[i] + 32'(idx[i]);
    end
  end

  always @(negedge clk) begin
    hs       <= rst ? 4'b0 : (req_valid & req_ready);
    mon_fire <= !rst && out_valid && out_ready;
    mon_l    <= L;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: advance requester models on completed handshakes, then score output words.
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i] === 1'b1) begin
        idx[i]       = idx[i] + 8'd1;
        remaining[i] = remaining[i] - 8'd1;
      end
    end
    if (mon_fire === 1'b1) begin
      chk("sb_extra_word", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) chk("L_word", 64'(mon_l), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic push_words(input int r, input int first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(base[r] + 32'(first + k));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
    cyc();
    cyc();
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      remaining[i] = 8'd0;
      idx[i]       = 8'd0;
      base[i]      = 32'hA000_0000 | (32'(i) << 24);
    end

    // 1: reset and idle
    repeat (3) cyc();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_L", 64'(L), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    cyc();
    cyc();
    chk("idle_grant", 64'(grant), 64'd0);
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    // 2: single requester, forced release after MAX_BURST, rr_ptr moves past it
    base[2]      = 32'hDEAD_BEEF;
    remaining[2] = 8'd6;
    out_ready    = 1'b1;
    push_words(2, 0, 4);
    cyc();
    chk("t2_grant", 64'(grant), 64'b0100);
    chk("t2_grant_id", 64'(grant_id), 64'd2);
    chk("t2_req_ready", 64'(req_ready), 64'b0100);
    cyc();
    chk("t2_L_first", 64'(L), 64'hDEAD_BEEF);
    chk("t2_out_valid", 64'(out_valid), 64'd1);
    cyc();
    cyc();
    chk("t2_grant_mid", 64'(grant), 64'b0100);
    remaining[3] = 8'd1;
    push_words(3, 0, 1);
    push_words(2, 4, 2);
    cyc();
    chk("t2_forced_release", 64'(grant), 64'd0);
    cyc();
    chk("t2_rr_ptr_3", 64'(grant), 64'b1000);
    drain("t2_drain");
    chk("t2_end_idle", 64'(grant), 64'd0);

    // 3: all four valid -> order 0,1,2,3,0
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx[i]       = 8'd0;
      remaining[i] = 8'd4;
    end
    remaining[0] = 8'd8;
    for (int i = 0; i < 4; i++) push_words(i, 0, 4);
    push_words(0, 4, 4);
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    prev  = 4'b0;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
      cyc();
      if (grant != 4'b0 && prev == 4'b0) gs.push_back(grant);
      prev = grant;
    end
    chk("t3_drain", 64'(exp_q.size()), 64'd0);
    chk("t3_grant_count", 64'(gs.size()), 64'd5);
    for (int k = 0; k < 5 && k < gs.size(); k++) chk("t3_grant_order", 64'(gs[k]), 64'(exp_g[k]));
    cyc();
    cyc();

    // 4: stall mid-burst; burst length must still be exactly MAX_BURST
    idx[0]       = 8'd0;
    idx[1]       = 8'd0;
    remaining[1] = 8'd6;
    remaining[0] = 8'd2;
    push_words(1, 0, 4);
    push_words(0, 0, 2);
    push_words(1, 4, 2);
    cyc();
    chk("t4_grant", 64'(grant), 64'b0010);
    cyc();
    cyc();
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cyc();
      chk("t4_stall_req_ready", 64'(req_ready), 64'd0);
      chk("t4_stall_L", 64'(L), 64'(base[1] + 32'd1));
      chk("t4_stall_out_valid", 64'(out_valid), 64'd1);
      chk("t4_stall_grant", 64'(grant), 64'b0010);
    end
    out_ready = 1'b1;
    drain("t4_drain");

    // 5: grantee drops valid after two words -> release, next requester granted
    idx[3]       = 8'd0;
    idx[0]       = 8'd0;
    remaining[3] = 8'd2;
    remaining[0] = 8'd1;
    push_words(3, 0, 2);
    push_words(0, 0, 1);
    cyc();
    chk("t5_grant", 64'(grant), 64'b1000);
    cyc();
    cyc();
    chk("t5_grant_hold", 64'(grant), 64'b1000);
    cyc();
    chk("t5_drop_release", 64'(grant), 64'd0);
    cyc();
    chk("t5_next_grant", 64'(grant), 64'b0001);
    chk("t5_next_grant_id", 64'(grant_id), 64'd0);
    drain("t5_drain");

    // 6: reset while busy with a held word discards it and clears rr_ptr
    idx[3]       = 8'd0;
    remaining[3] = 8'd4;
    out_ready    = 1'b0;
    cyc();
    chk("t6_grant", 64'(grant), 64'b1000);
    cyc();
    chk("t6_held_valid", 64'(out_valid), 64'd1);
    chk("t6_held_L", 64'(L), 64'(base[3]));
    rst = 1'b1;
    cyc();
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_grant", 64'(grant), 64'd0);
    chk("t6_rst_L", 64'(L), 64'd0);
    rst          = 1'b0;
    out_ready    = 1'b1;
    idx[0]       = 8'd0;
    remaining[0] = 8'd1;
    push_words(0, 0, 1);
    push_words(3, 1, 3);
    cyc();
    chk("t6_rr_ptr_reset", 64'(grant), 64'b0001);
    drain("t6_drain");

    chk("sb_final_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
